// File: rtl/counter_pkg.sv
// counter_pkg: mode encoding and direction type shared by the prescaled counter
package counter_pkg;
   localparam logic [1:0] MODE_UP     = 2'b00;
   localparam logic [1:0] MODE_DOWN   = 2'b01;
   localparam logic [1:0] MODE_BOUNCE = 2'b10;
   localparam logic [1:0] MODE_HOLD   = 2'b11;
   typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running 0..div divider, tick is the combinational terminal flag
module tick_prescaler #(
   parameter int DIV_W = 22
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);
   logic [DIV_W-1:0] psc;
   // >= so that lowering div below the running value ends the period at once
   assign tick = en && (psc >= div);
   always_ff @(posedge clk) begin
      if (rst || clr) psc <= '0;
      else if (en) psc <= tick ? '0 : psc + 1'b1;
   end
endmodule

// File: rtl/prescaled_counter.sv
// prescaled_counter: up/down/bounce/hold counter advanced by a prescaler tick or a manual step edge
module prescaled_counter
   import counter_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DIV_W    = 22,
   parameter int GRAY_OUT = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [DIV_W-1:0] div,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             step,
   output logic [WIDTH-1:0] cnt_out,
   output logic             tick,
   output logic             wrap
);
   localparam logic [WIDTH-1:0] MAX = '1;
   logic term, step_q, step_armed, adv, rev, w;
   dir_e dir, nxt_dir;
   logic [WIDTH-1:0] cnt, nxt, cnt_d;
   tick_prescaler #(.DIV_W(DIV_W)) u_psc (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .clr  (load),
      .div  (div),
      .tick (term)
   );
   // step_armed stays low until step is seen low, so a step held through reset needs a fresh edge
   assign adv = term || (!en && step && !step_q && step_armed);
   always_comb begin
      nxt = cnt;
      nxt_dir = DIR_UP;
      rev = 1'b0;
      w = 1'b0;
      if (mode == MODE_UP) begin
         nxt = cnt + 1'b1;
         w = cnt == MAX;
      end else if (mode == MODE_DOWN) begin
         nxt = cnt - 1'b1;
         w = cnt == '0;
      end else if (mode == MODE_BOUNCE) begin
         rev = (dir == DIR_UP) ? cnt == MAX : cnt == '0;
         nxt_dir = ((dir == DIR_UP) ^ rev) ? DIR_UP : DIR_DOWN;
         nxt = (nxt_dir == DIR_UP) ? cnt + 1'b1 : cnt - 1'b1;
         w = rev || (WIDTH == 1);
      end
      cnt_d = load ? load_val : adv ? nxt : cnt;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         cnt_out <= '0;
         dir <= DIR_UP;
         tick <= 1'b0;
         wrap <= 1'b0;
         step_q <= 1'b0;
         step_armed <= 1'b0;
      end else begin
         cnt <= cnt_d;
         cnt_out <= (GRAY_OUT != 0) ? cnt_d ^ (cnt_d >> 1) : cnt_d;
         tick <= term;
         wrap <= adv && !load && w;
         step_q <= step;
         step_armed <= step_armed || !step;
         dir <= (mode != MODE_BOUNCE) ? DIR_UP : (adv && !load) ? nxt_dir : dir;
      end
   end
endmodule

// File: tb/tb_prescaled_counter.sv
// tb_prescaled_counter: directed and random stimulus against an arithmetic reference model
module tb_prescaled_counter;
   import counter_pkg::*;
   logic clk = 1'b0;
   logic rst, en, load, step;
   logic [1:0] mode;
   logic [21:0] div;
   logic [7:0] load_val;
   logic [7:0] cnt_b, cnt_g;
   logic [0:0] cnt_1;
   logic tick_b, tick_g, tick_1, wrap_b, wrap_g, wrap_1;
   int checks = 0, failures = 0;
   int w[3] = '{8, 8, 1};
   int m_cnt[3], m_dir[3], m_wrap[3];
   int m_psc, m_tick, m_prev, m_armed;
   always #5 clk = ~clk;
   prescaled_counter #(.WIDTH(8), .DIV_W(22), .GRAY_OUT(0)) dut_b (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .div(div), .load(load),
      .load_val(load_val), .step(step), .cnt_out(cnt_b), .tick(tick_b), .wrap(wrap_b));
   prescaled_counter #(.WIDTH(8), .DIV_W(22), .GRAY_OUT(1)) dut_g (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .div(div), .load(load),
      .load_val(load_val), .step(step), .cnt_out(cnt_g), .tick(tick_g), .wrap(wrap_g));
   prescaled_counter #(.WIDTH(1), .DIV_W(22), .GRAY_OUT(0)) dut_1 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .div(div), .load(load),
      .load_val(load_val[0:0]), .step(step), .cnt_out(cnt_1), .tick(tick_1), .wrap(wrap_1));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
      end
   endtask
   // next-edge behaviour computed from the current inputs with plain integer arithmetic
   task automatic model();
      int term, adv, m;
      if (rst) begin
         m_psc = 0; m_tick = 0; m_prev = 0; m_armed = 0;
         for (int i = 0; i < 3; i++) begin m_cnt[i] = 0; m_dir[i] = 1; m_wrap[i] = 0; end
         return;
      end
      term = (en && m_psc >= int'(div)) ? 1 : 0;
      adv = (term || (!en && step && !m_prev && m_armed)) ? 1 : 0;
      m_prev = step;
      if (!step) m_armed = 1;
      m_tick = term;
      m_psc = (load || term) ? 0 : en ? m_psc + 1 : m_psc;
      for (int i = 0; i < 3; i++) begin
         m = 1 << w[i];
         m_wrap[i] = 0;
         if (load) m_cnt[i] = int'(load_val) % m;
         else if (adv) begin
            if (mode == MODE_UP) begin
               m_wrap[i] = (m_cnt[i] == m - 1) ? 1 : 0;
               m_cnt[i] = (m_cnt[i] + 1) % m;
            end else if (mode == MODE_DOWN) begin
               m_wrap[i] = (m_cnt[i] == 0) ? 1 : 0;
               m_cnt[i] = (m_cnt[i] + m - 1) % m;
            end else if (mode == MODE_BOUNCE) begin
               if (m_cnt[i] + m_dir[i] < 0 || m_cnt[i] + m_dir[i] >= m) begin
                  m_dir[i] = -m_dir[i];
                  m_wrap[i] = 1;
               end
               if (m == 2) m_wrap[i] = 1;
               m_cnt[i] = m_cnt[i] + m_dir[i];
            end
         end
         if (mode != MODE_BOUNCE) m_dir[i] = 1;
      end
   endtask
   task automatic cycle(input logic r, input logic e, input logic [1:0] md, input int dv,
                        input logic ld, input int lv, input logic st);
      @(negedge clk);
      check("cnt_bin", cnt_b, m_cnt[0]);
      check("cnt_gray", cnt_g, m_cnt[1] ^ (m_cnt[1] >> 1));
      check("cnt_w1", cnt_1, m_cnt[2]);
      check("tick_bin", tick_b, m_tick);
      check("tick_gray", tick_g, m_tick);
      check("tick_w1", tick_1, m_tick);
      check("wrap_bin", wrap_b, m_wrap[0]);
      check("wrap_gray", wrap_g, m_wrap[1]);
      check("wrap_w1", wrap_1, m_wrap[2]);
      rst = r; en = e; mode = md; div = 22'(dv); load = ld; load_val = 8'(lv); step = st;
      model();
   endtask
   initial begin
      int dv, lv;
      logic st;
      rst = 1'b1; en = 1'b0; mode = MODE_UP; div = '0; load = 1'b0; load_val = '0; step = 1'b0;
      model();
      cycle(1, 0, MODE_UP, 3, 0, 0, 0);
      repeat (1035) cycle(0, 1, MODE_UP, 3, 0, 0, 0);
      cycle(0, 1, MODE_BOUNCE, 0, 1, 254, 0);
      repeat (6) cycle(0, 1, MODE_BOUNCE, 0, 0, 0, 0);
      cycle(0, 1, MODE_DOWN, 0, 1, 0, 0);
      repeat (3) cycle(0, 1, MODE_DOWN, 0, 0, 0, 0);
      repeat (4) cycle(0, 1, MODE_HOLD, 0, 0, 0, 0);
      repeat (2) cycle(0, 0, MODE_UP, 0, 0, 0, 0);
      repeat (5) cycle(0, 0, MODE_UP, 0, 0, 0, 1);
      repeat (2) cycle(0, 0, MODE_UP, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) cycle(0, 1, MODE_UP, 7, 0, 0, logic'(i % 2));
      cycle(1, 0, MODE_UP, 0, 0, 0, 1);
      repeat (4) cycle(0, 0, MODE_UP, 0, 0, 0, 1);
      cycle(0, 0, MODE_UP, 0, 0, 0, 0);
      cycle(0, 0, MODE_UP, 0, 0, 0, 1);
      repeat (3) cycle(0, 1, MODE_UP, 0, 0, 0, 0);
      cycle(0, 1, MODE_UP, 0, 1, 100, 0);
      repeat (5) cycle(0, 1, MODE_UP, 9, 0, 0, 0);
      cycle(0, 1, MODE_UP, 2, 0, 0, 0);
      cycle(1, 1, MODE_UP, 0, 1, 77, 1);
      repeat (6) cycle(0, 1, MODE_UP, 0, 0, 0, 0);
      dv = 2;
      st = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) dv = $urandom_range(0, 5);
         if ($urandom_range(0, 2) == 0) st = ~st;
         case ($urandom_range(0, 4))
            0: lv = 0;
            1: lv = 1;
            2: lv = 254;
            3: lv = 255;
            default: lv = $urandom_range(0, 255);
         endcase
         cycle(logic'($urandom_range(0, 199) == 0), logic'($urandom_range(0, 3) != 0),
               2'($urandom_range(0, 3)), dv, logic'($urandom_range(0, 24) == 0), lv, st);
      end
      cycle(0, 0, MODE_HOLD, 0, 0, 0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
